data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 174 +++++++++++++++++
 tb/tb_data_memory.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: word-addressed 32-bit data memory with byte write strobes,
// a programmable wait-state handshake and out-of-range access detection.
// Optional feature macro: DMEM_WAIT_STATES_EN. When it is defined, WAIT_STATES
// extra cycles are inserted per access. When it is undefined, there is no wait
// counter and every access completes on the edge after acceptance, with the
// ready outputs held high.
module data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_rdy,
  input  logic        write_enable,
  input  logic [3:0]  write_byte_enable,
  input  logic [31:0] write_data,
  output logic        write_rdy,
  output logic        access_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  if (DEPTH_WORDS < 16 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 ||
      WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_param
    $error("data_memory: DEPTH_WORDS must be a power of two >= 16, WAIT_STATES 0..15");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          accept;
  logic          complete_rd;
  logic          complete_wr;
  logic          cnt_zero;

  // Byte address reduced to a word address; the byte offset is dropped here.
  logic [29:0]   word_addr;
  assign word_addr = 30'(address >> 2);

  logic [AW-1:0] idx_q;
  logic          oor_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wbe_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   read_data_q;
  logic          read_rdy_q, read_rdy_d;
  logic          write_rdy_q, write_rdy_d;
  logic          access_error_q, access_error_d;

`ifdef DMEM_WAIT_STATES_EN
  logic [3:0]    cnt_q, cnt_d;

  assign cnt_zero = (cnt_q == 4'd0);

  // Wait counter: loaded on acceptance, counts down while an access is pending.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = 4'(WAIT_STATES);
    end else if (state_q != IDLE && !cnt_zero) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // No wait counter: a pending access always completes on the next edge.
  assign cnt_zero = 1'b1;
`endif

  // Next-state logic; a write wins over a simultaneous read.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    complete_rd = 1'b0;
    complete_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_enable) begin
          state_d = WR_WAIT;
          accept  = 1'b1;
        end else if (read_enable) begin
          state_d = RD_WAIT;
          accept  = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_zero) begin
          state_d     = IDLE;
          complete_rd = 1'b1;
        end
      end
      WR_WAIT: begin
        if (cnt_zero) begin
          state_d     = IDLE;
          complete_wr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready drops on the edge after acceptance and stays low while the counter
  // is non-zero, so it is low for exactly WAIT_STATES cycles and rises
  // together with the completed result.
  always_comb begin
    read_rdy_d     = !(state_q == RD_WAIT && !cnt_zero);
    write_rdy_d    = !(state_q == WR_WAIT && !cnt_zero);
    access_error_d = (complete_rd || complete_wr) && oor_q;
  end

  // Control state, handshake outputs and the read result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      read_rdy_q     <= 1'b1;
      write_rdy_q    <= 1'b1;
      access_error_q <= 1'b0;
      read_data_q    <= 32'h0;
    end else begin
      state_q        <= state_d;
      read_rdy_q     <= read_rdy_d;
      write_rdy_q    <= write_rdy_d;
      access_error_q <= access_error_d;
      if (complete_rd) begin
        read_data_q <= oor_q ? 32'h0 : mem_q[idx_q];
      end
    end
  end

  // Request capture at acceptance; held stable for the whole access.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= word_addr[AW-1:0];
      oor_q   <= |word_addr[29:AW];
      wdata_q <= write_data;
      wbe_q   <= write_byte_enable;
    end
  end

  // Storage array: strobed byte writes at completion; never cleared by reset,
  // and a reset on the completion edge cancels the write.
  always_ff @(posedge clk) begin
    if (complete_wr && !oor_q && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign read_data    = read_data_q;
  assign read_rdy     = read_rdy_q;
  assign write_rdy    = write_rdy_q;
  assign access_error = access_error_q;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized and directed stimulus for data_memory against a
// word-array reference model. Builds with or without DMEM_WAIT_STATES_EN.
module tb_data_memory;

`ifdef DMEM_WAIT_STATES_EN
  localparam int WS_PARAM = 2;
  localparam int WS       = 2;
`else
  localparam int WS_PARAM = 5;
  localparam int WS       = 0;
`endif
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = 32'h0;
  logic        read_enable = 1'b0;
  logic [31:0] read_data;
  logic        read_rdy;
  logic        write_enable = 1'b0;
  logic [3:0]  write_byte_enable = 4'h0;
  logic [31:0] write_data = 32'h0;
  logic        write_rdy;
  logic        access_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] model_rd;

  data_memory #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS_PARAM)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .address          (address),
    .read_enable      (read_enable),
    .read_data        (read_data),
    .read_rdy         (read_rdy),
    .write_enable     (write_enable),
    .write_byte_enable(write_byte_enable),
    .write_data       (write_data),
    .write_rdy        (write_rdy),
    .access_error     (access_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete access: present the request, watch the handshake for the
  // whole wait window, then check the result and the error pulse.
  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic do_access(input bit re, input bit we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd, input bit poke);
    bit oor;
    int idx;
    int lows;
    oor = (addr[31:2] >= 30'(DEPTH));
    idx = int'(addr[11:2]);
    read_enable       = re;
    write_enable      = we;
    address           = addr;
    write_byte_enable = be;
    write_data        = wd;
    @(posedge clk); #1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    if (poke && WS > 0) begin
      read_enable       = 1'b1;
      write_enable      = 1'b1;
      address           = $urandom_range(DEPTH - 1) << 2;
      write_byte_enable = 4'hf;
      write_data        = $urandom;
    end
    lows = 0;
    for (int j = 0; j <= WS; j++) begin
      if ((we ? write_rdy : read_rdy) == 1'b0) lows++;
      chk("other_rdy_high", 32'(we ? read_rdy : write_rdy), 32'd1);
      chk("no_err_in_wait", 32'(access_error), 32'd0);
      chk("rd_data_held", read_data, model_rd);
      @(posedge clk); #1;
      read_enable  = 1'b0;
      write_enable = 1'b0;
    end
    chk("rdy_low_cycles", 32'(lows), 32'(WS));
    chk("rdy_back_high", 32'(we ? write_rdy : read_rdy), 32'd1);
    if (we) begin
      if (!oor) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end else begin
      model_rd = oor ? 32'h0 : ref_mem[idx];
    end
    chk("rd_data", read_data, model_rd);
    chk("err_pulse", 32'(access_error), 32'(oor));
    @(posedge clk); #1;
    chk("err_one_cycle", 32'(access_error), 32'd0);
    chk("rd_data_after", read_data, model_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read_rdy"}, 32'(read_rdy), 32'd1);
    chk({tag, "_write_rdy"}, 32'(write_rdy), 32'd1);
    chk({tag, "_read_data"}, read_data, 32'h0);
    chk({tag, "_err"}, 32'(access_error), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w0_before;
    int          sel;
    bit          r;
    bit          w;

    model_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) begin
      do_access(1'b0, 1'b1, 32'(i) << 2, 4'hf, $urandom, 1'b0);
    end

    // Full-word write then read back.
    do_access(1'b0, 1'b1, 32'h10, 4'hf, 32'hDEADBEEF, 1'b1);
    do_access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
    chk("deadbeef", read_data, 32'hDEADBEEF);

    // Single-byte strobe.
    do_access(1'b0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, 1'b0);
    do_access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    chk("byte_strobe", read_data, 32'hDEAABEEF);

    // Empty strobe leaves the word alone.
    do_access(1'b0, 1'b1, 32'h10, 4'b0000, 32'h11111111, 1'b0);
    do_access(1'b1, 1'b0, 32'h13, 4'h0, 32'h0, 1'b0);
    chk("zero_strobe", read_data, 32'hDEAABEEF);

    // Simultaneous read and write: the write wins, read_data untouched.
    do_access(1'b1, 1'b1, 32'h20, 4'hf, 32'h12345678, 1'b0);
    do_access(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    chk("rw_collision", read_data, 32'h12345678);

    // Out of range: read returns zero, write leaves the aliased word 0 alone.
    w0_before = ref_mem[0];
    do_access(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b0);
    chk("oor_read_zero", read_data, 32'h0);
    do_access(1'b0, 1'b1, 32'h1000, 4'hf, 32'hCAFEF00D, 1'b0);
    do_access(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("oor_write_dropped", read_data, w0_before);

    // Last in-range word.
    do_access(1'b0, 1'b1, 32'hFFC, 4'hf, 32'hA5A5_5A5A, 1'b0);
    do_access(1'b1, 1'b0, 32'hFFF, 4'h0, 32'h0, 1'b0);
    chk("top_word", read_data, 32'hA5A5_5A5A);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(9);
      if (sel == 0) begin
        a = $urandom;
        if (a < 32'h1000) a = a | 32'h1000;
      end else if (sel == 1) begin
        a = 32'h1000 + 32'($urandom_range(15));
      end else begin
        a = (32'($urandom_range(DEPTH - 1)) << 2) | 32'($urandom_range(3));
      end
      r = 1'($urandom_range(1));
      w = 1'($urandom_range(1));
      if (!r && !w) r = 1'b1;
      do_access(r, w, a, 4'($urandom_range(15)), $urandom, 1'($urandom_range(1)));
    end

    // Reset while a write is pending.
`ifdef DMEM_WAIT_STATES_EN
    write_enable      = 1'b1;
    address           = 32'h30;
    write_byte_enable = 4'hf;
    write_data        = 32'h55555555;
    @(posedge clk); #1;
    write_enable = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`else
    write_enable      = 1'b1;
    address           = 32'h30;
    write_byte_enable = 4'hf;
    write_data        = 32'h55555555;
    rst               = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
    rst          = 1'b0;
`endif
    model_rd = 32'h0;
    check_reset_outputs("reset_mid");
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, 1'b0);
    chk("reset_kept_mem", read_data, ref_mem[12]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
